// File: rtl/potential_reader.sv
// rtl/potential_reader.sv - sweeps potential memory and streams each potential with its neuron id
// Two-entry FIFO plus one in-flight read keeps throughput at one potential per cycle.
module potential_reader #(
  parameter int NEURON_COUNT = 32,
  parameter int ADDR_WIDTH   = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [31:0]           mem_rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_potential,
  output logic [ADDR_WIDTH-1:0] out_neuron_id,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic {IDLE, SWEEP} state_t;

  localparam logic [ADDR_WIDTH:0] NC = (ADDR_WIDTH+1)'(NEURON_COUNT);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   out_cnt_q, out_cnt_d;
  logic                  inflight_q, inflight_d;
  logic [ADDR_WIDTH-1:0] inflight_id_q, inflight_id_d;
  logic [31:0]           buf_data_q [2];
  logic [31:0]           buf_data_d [2];
  logic [ADDR_WIDTH-1:0] buf_id_q [2];
  logic [ADDR_WIDTH-1:0] buf_id_d [2];
  logic                  head_q, head_d;
  logic [1:0]            count_q, count_d;
  logic                  done_q, done_d;

  logic                  pop;
  logic                  issue;
  logic [2:0]            occ;
  logic                  wr_idx;

  always_comb begin
    state_d       = state_q;
    rd_ptr_d      = rd_ptr_q;
    out_cnt_d     = out_cnt_q;
    inflight_d    = 1'b0;
    inflight_id_d = inflight_id_q;
    buf_data_d    = buf_data_q;
    buf_id_d      = buf_id_q;
    head_d        = head_q;
    done_d        = 1'b0;

    pop    = (count_q != 2'd0) && out_ready;
    // occupancy after this cycle: what is buffered, plus what is arriving, minus what leaves
    occ    = 3'(count_q) + 3'(inflight_q) - 3'(pop);
    issue  = (state_q == SWEEP) && (rd_ptr_q < NC) && (occ < 3'd2);
    wr_idx = head_q ^ count_q[0];

    mem_rd_en   = issue;
    mem_rd_addr = issue ? rd_ptr_q[ADDR_WIDTH-1:0] : '0;

    if (inflight_q) begin
      buf_data_d[wr_idx] = mem_rd_data;
      buf_id_d[wr_idx]   = inflight_id_q;
    end
    if (pop) begin
      head_d = ~head_q;
    end
    count_d = count_q + 2'(inflight_q) - 2'(pop);

    if (issue) begin
      inflight_d    = 1'b1;
      inflight_id_d = rd_ptr_q[ADDR_WIDTH-1:0];
      rd_ptr_d      = rd_ptr_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = SWEEP;
          rd_ptr_d   = '0;
          out_cnt_d  = '0;
          head_d     = 1'b0;
          count_d    = 2'd0;
          inflight_d = 1'b0;
        end
      end
      SWEEP: begin
        if (pop) begin
          out_cnt_d = out_cnt_q + 1'b1;
          if (out_cnt_d == NC) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      rd_ptr_q      <= '0;
      out_cnt_q     <= '0;
      inflight_q    <= 1'b0;
      inflight_id_q <= '0;
      buf_data_q    <= '{default: '0};
      buf_id_q      <= '{default: '0};
      head_q        <= 1'b0;
      count_q       <= 2'd0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      rd_ptr_q      <= rd_ptr_d;
      out_cnt_q     <= out_cnt_d;
      inflight_q    <= inflight_d;
      inflight_id_q <= inflight_id_d;
      buf_data_q    <= buf_data_d;
      buf_id_q      <= buf_id_d;
      head_q        <= head_d;
      count_q       <= count_d;
      done_q        <= done_d;
    end
  end

  assign out_valid     = (count_q != 2'd0);
  assign out_potential = buf_data_q[head_q];
  assign out_neuron_id = buf_id_q[head_q];
  assign busy          = (state_q == SWEEP);
  assign done          = done_q;

endmodule

// File: tb/tb_potential_reader.sv
// tb/tb_potential_reader.sv - self-checking bench for potential_reader
// Three instances (4, 32 and 1 neurons) share clock and reset; a stream model checks every cycle.
module tb_potential_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        st    [3];
  logic        rdy   [3];
  logic        rd_en [3];
  logic [4:0]  addr  [3];
  logic [31:0] rdata [3];
  logic        vld   [3];
  logic [31:0] pot   [3];
  logic [4:0]  id    [3];
  logic        busy  [3];
  logic        done  [3];

  logic [31:0] mem [3][32];
  int          ncnt [3] = '{4, 32, 1};

  int checks = 0;
  int errors = 0;

  int          issued [3];
  int          hs     [3];
  int          exp_id [3];
  int          exp_addr [3];
  int          last_id [3];
  bit          pend   [3];
  bit          pv     [3];
  bit          pr     [3];
  logic [4:0]  pid    [3];
  logic [31:0] ppot   [3];

  always #5 clk = ~clk;

  potential_reader #(.NEURON_COUNT(4), .ADDR_WIDTH(5)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .mem_rd_en(rd_en[0]), .mem_rd_addr(addr[0]),
    .mem_rd_data(rdata[0]), .out_valid(vld[0]), .out_ready(rdy[0]), .out_potential(pot[0]),
    .out_neuron_id(id[0]), .busy(busy[0]), .done(done[0]));

  potential_reader #(.NEURON_COUNT(32), .ADDR_WIDTH(5)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .mem_rd_en(rd_en[1]), .mem_rd_addr(addr[1]),
    .mem_rd_data(rdata[1]), .out_valid(vld[1]), .out_ready(rdy[1]), .out_potential(pot[1]),
    .out_neuron_id(id[1]), .busy(busy[1]), .done(done[1]));

  potential_reader #(.NEURON_COUNT(1), .ADDR_WIDTH(5)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(st[2]), .mem_rd_en(rd_en[2]), .mem_rd_addr(addr[2]),
    .mem_rd_data(rdata[2]), .out_valid(vld[2]), .out_ready(rdy[2]), .out_potential(pot[2]),
    .out_neuron_id(id[2]), .busy(busy[2]), .done(done[2]));

  // synchronous RAM with one cycle read latency
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rd_en[k]) rdata[k] <= mem[k][addr[k]];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Stream model: reads and handshakes must walk 0..N-1 in order, done follows the N-th handshake
  always @(negedge clk) begin
    #2;
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        chk($sformatf("reset_outputs[%0d]", k),
            {rd_en[k], addr[k], vld[k], pot[k], id[k], busy[k], done[k]}, 64'd0);
        issued[k] = 0; hs[k] = 0; exp_id[k] = 0; exp_addr[k] = 0;
        pend[k] = 1'b0; pv[k] = 1'b0; pr[k] = 1'b0;
      end else begin
        chk($sformatf("done_timing[%0d]", k), done[k], pend[k]);
        pend[k] = 1'b0;
        if (done[k]) chk($sformatf("busy_with_done[%0d]", k), busy[k], 1'b0);
        if (pv[k] && !pr[k])
          chk($sformatf("hold_stable[%0d]", k), {vld[k], id[k], pot[k]}, {1'b1, pid[k], ppot[k]});
        if (rd_en[k]) begin
          issued[k]++;
          chk($sformatf("rd_addr[%0d]", k), addr[k], exp_addr[k]);
          exp_addr[k] = (exp_addr[k] + 1) % ncnt[k];
        end
        if (vld[k] && rdy[k]) begin
          chk($sformatf("out_id[%0d]", k), id[k], exp_id[k]);
          chk($sformatf("out_data[%0d]", k), pot[k], mem[k][exp_id[k]]);
          last_id[k] = exp_id[k];
          hs[k]++;
          exp_id[k]++;
          if (exp_id[k] == ncnt[k]) begin
            exp_id[k] = 0;
            pend[k] = 1'b1;
          end
        end
        chk($sformatf("outstanding_le2[%0d]", k), (issued[k] - hs[k]) <= 2, 1'b1);
        pv[k] = vld[k]; pr[k] = rdy[k]; pid[k] = id[k]; ppot[k] = pot[k];
      end
    end
  end

  task automatic pulse_start(input int k);
    @(negedge clk); st[k] = 1'b1;
    @(negedge clk); st[k] = 1'b0;
  endtask

  task automatic wait_done(input int k, input int maxc, input bit restart, input bit rnd);
    bit found = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (rnd) rdy[k] = 1'($urandom % 2);
      if (done[k]) begin
        found = 1'b1;
        if (restart) st[k] = 1'b1;
        break;
      end
    end
    chk($sformatf("done_seen[%0d]", k), found, 1'b1);
    if (restart) begin
      @(negedge clk); st[k] = 1'b0;
    end
  endtask

  typedef struct {
    bit         ready;
    bit         valid;
    logic [4:0] nid;
    bit         rd;
    logic [4:0] raddr;
    bit         bsy;
    bit         dn;
  } vec_t;

  vec_t tbl [9];

  initial begin
    int base, cnt;
    bit ok;

    // cycle-by-cycle sweep of the 4-neuron instance, one stall cycle at row 3
    tbl[0] = '{1'b1, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 5'd0, 1'b1, 5'd1, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 5'd0, 1'b1, 5'd2, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 5'd1, 1'b0, 5'd0, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 5'd1, 1'b1, 5'd3, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0};
    tbl[6] = '{1'b1, 1'b1, 5'd3, 1'b0, 5'd0, 1'b1, 1'b0};
    tbl[7] = '{1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1};
    tbl[8] = '{1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0};

    for (int k = 0; k < 3; k++) begin
      st[k] = 1'b0; rdy[k] = 1'b1;
      for (int a = 0; a < 32; a++) mem[k][a] = (k == 0) ? 32'h3F80_0000 + a : $urandom;
    end

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    pulse_start(0);
    for (int r = 0; r < 9; r++) begin
      rdy[0] = tbl[r].ready;
      #1;
      chk($sformatf("tbl%0d_valid", r), vld[0], tbl[r].valid);
      if (tbl[r].valid) begin
        chk($sformatf("tbl%0d_id", r), id[0], tbl[r].nid);
        chk($sformatf("tbl%0d_data", r), pot[0], 32'h3F80_0000 + 32'(tbl[r].nid));
      end
      chk($sformatf("tbl%0d_rd_en", r), rd_en[0], tbl[r].rd);
      if (tbl[r].rd) chk($sformatf("tbl%0d_rd_addr", r), addr[0], tbl[r].raddr);
      chk($sformatf("tbl%0d_busy", r), busy[0], tbl[r].bsy);
      chk($sformatf("tbl%0d_done", r), done[0], tbl[r].dn);
      @(negedge clk);
    end

    // backpressure: only two reads may be issued while the consumer stalls
    rdy[1] = 1'b0;
    pulse_start(1);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (rd_en[1]) cnt++;
      @(negedge clk);
    end
    chk("bp_read_count", cnt, 2);
    chk("bp_head", {vld[1], id[1]}, {1'b1, 5'd0});
    base = hs[1];
    rdy[1] = 1'b1;
    wait_done(1, 100, 1'b0, 1'b0);
    chk("bp_handshakes", hs[1] - base, 32);
    chk("bp_last_id", last_id[1], 31);

    // random consumer readiness over a full 32-neuron sweep
    base = hs[1];
    pulse_start(1);
    wait_done(1, 600, 1'b0, 1'b1);
    chk("rnd_handshakes", hs[1] - base, 32);
    rdy[1] = 1'b1;

    // start while busy is ignored; start on the done cycle restarts
    base = hs[1];
    pulse_start(1);
    repeat (4) @(negedge clk);
    st[1] = 1'b1;
    @(negedge clk); st[1] = 1'b0;
    wait_done(1, 100, 1'b1, 1'b0);
    chk("busy_restart_first", hs[1] - base, 32);
    #1 chk("restart_busy", busy[1], 1'b1);
    wait_done(1, 100, 1'b0, 1'b0);
    chk("restart_total", hs[1] - base, 64);

    // reset in mid-sweep
    base = hs[1];
    pulse_start(1);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (hs[1] - base >= 3) begin ok = 1'b1; break; end
    end
    chk("mid_hs_reached", ok, 1'b1);
    rst_n = 1'b0;
    #1 chk("mid_reset_outputs", {rd_en[1], vld[1], busy[1], done[1], pot[1], id[1]}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1 chk("post_reset_quiet", {rd_en[1], vld[1], busy[1]}, 3'b000);
    end
    base = hs[1];
    pulse_start(1);
    wait_done(1, 100, 1'b0, 1'b0);
    chk("post_reset_sweep", hs[1] - base, 32);

    // single-neuron instance
    base = hs[2];
    pulse_start(2);
    wait_done(2, 20, 1'b0, 1'b0);
    chk("n1_handshakes", hs[2] - base, 1);
    chk("n1_last_id", last_id[2], 0);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
